// File: rtl/adam_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adam_stream_fifo
// Description : First-word-fall-through stream FIFO for any DEPTH >= 2.
//               Upstream ready is derived from registered occupancy only.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_stream_fifo #(
    parameter type data_t = logic,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  data_t            i_slv_data,
    input  logic             i_slv_valid,
    output logic             o_slv_ready,
    output data_t            o_mst_data,
    output logic             o_mst_valid,
    input  logic             i_mst_ready,
    output logic [CNT_W-1:0] o_count
);

    localparam int               c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_full     = CNT_W'(DEPTH);

    data_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic w_push;
    logic w_pop;

    // Ready ignores i_mst_ready on purpose: a full FIFO refuses a beat even
    // when the head is leaving, keeping the ready path free of downstream logic.
    assign o_slv_ready = !rst && (r_cnt != c_full);
    assign o_mst_valid = (r_cnt != '0);
    assign o_mst_data  = r_mem[r_rd_ptr];
    assign o_count     = r_cnt;

    assign w_push = i_slv_valid && o_slv_ready;
    assign w_pop  = o_mst_valid && i_mst_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_slv_data;
        end
    end

    // Explicit wrap compare: DEPTH need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adam_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adam_stream_fifo
// Description : Scoreboard bench for adam_stream_fifo at DEPTH=4 and DEPTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adam_stream_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] d4 = '0, d3 = '0;
    logic       v4 = 1'b0, v3 = 1'b0;
    logic       r4 = 1'b0, r3 = 1'b0;

    logic       rdy4, rdy3, val4, val3;
    logic [7:0] q4_data, q3_data;
    logic [2:0] cnt4;
    logic [1:0] cnt3;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp4 [$];
    logic [7:0] exp3 [$];

    always #5 clk = ~clk;

    adam_stream_fifo #(.data_t(logic [7:0]), .DEPTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .i_slv_data  (d4),
        .i_slv_valid (v4),
        .o_slv_ready (rdy4),
        .o_mst_data  (q4_data),
        .o_mst_valid (val4),
        .i_mst_ready (r4),
        .o_count     (cnt4)
    );

    adam_stream_fifo #(.data_t(logic [7:0]), .DEPTH(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .i_slv_data  (d3),
        .i_slv_valid (v3),
        .o_slv_ready (rdy3),
        .o_mst_data  (q3_data),
        .o_mst_valid (val3),
        .i_mst_ready (r3),
        .o_count     (cnt3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each FIFO is just a queue of accepted beats. A beat is
    // accepted when valid and the queue holds fewer than DEPTH entries.
    always @(posedge clk) begin
        bit pu4, po4, pu3, po3;
        if (rst) begin
            exp4.delete();
            exp3.delete();
        end else begin
            pu4 = v4 && (exp4.size() < 4);
            po4 = r4 && (exp4.size() != 0);
            pu3 = v3 && (exp3.size() < 3);
            po3 = r3 && (exp3.size() != 0);
            if (po4) void'(exp4.pop_front());
            if (pu4) exp4.push_back(d4);
            if (po3) void'(exp3.pop_front());
            if (pu3) exp3.push_back(d3);
        end
    end

    // Monitor, sampled mid-cycle.
    always @(negedge clk) begin
        chk("ready4", int'(rdy4), int'(!rst && exp4.size() < 4));
        chk("valid4", int'(val4), int'(exp4.size() != 0));
        chk("count4", int'(cnt4), exp4.size());
        if (exp4.size() != 0) chk("data4", int'(q4_data), int'(exp4[0]));
        chk("ready3", int'(rdy3), int'(!rst && exp3.size() < 3));
        chk("valid3", int'(val3), int'(exp3.size() != 0));
        chk("count3", int'(cnt3), exp3.size());
        if (exp3.size() != 0) chk("data3", int'(q3_data), int'(exp3[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset held with valid asserted
        v4 = 1'b1; d4 = 8'hEE;
        repeat (3) step();
        rst = 1'b0; v4 = 1'b0;
        step();

        // Fill with downstream stalled, attempt a push on full, then drain
        r4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; d4 = fill[i];
            step();
        end
        d4 = 8'h99;
        step();
        v4 = 1'b0; r4 = 1'b1;
        repeat (5) step();
        r4 = 1'b0;

        // Continuous streaming
        v4 = 1'b1; r4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d4 = 8'(i);
            step();
        end
        v4 = 1'b0;
        repeat (2) step();
        r4 = 1'b0;

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; d4 = 8'($urandom);
            step();
        end
        r4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d4 = 8'($urandom);
            step();
        end
        v4 = 1'b0;
        repeat (6) step();
        r4 = 1'b0;

        // Reset mid-operation discards stored beats
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; d4 = 8'hA0 + 8'(i);
            step();
        end
        v4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        v4 = 1'b1; d4 = 8'h55;
        step();
        v4 = 1'b0; r4 = 1'b1;
        repeat (3) step();
        r4 = 1'b0;

        // Non-power-of-two depth under random traffic
        for (int i = 0; i < 2000; i++) begin
            v3 = 1'($urandom_range(0, 1));
            r3 = 1'($urandom_range(0, 1));
            d3 = 8'($urandom);
            step();
        end
        v3 = 1'b0; r3 = 1'b1;
        repeat (4) step();
        r3 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
